axi_stream_checker: RTL and testbench
=====================================

# axi_stream_checker

Downstream AXI4-Stream video sink for the pattern-generator test chain. It consumes the 16-bit pixel stream produced by the stream generator: tuser marks start of frame (SOF) and tlast marks end of line (EOL). It drives tready with an optional periodic backpressure pattern and checks the stream's framing against HSIZE × VSIZE. Per completed frame it reports pass/fail, a data checksum and a frame count, and it keeps sticky error flags for the bench.

## Interface
- HSIZE, 1920, pixels per line
- VSIZE, 3, lines per frame
- READY_PERIOD, 4, backpressure period in cycles; 0 disables backpressure
- clk_in  input  1  single clock, all logic on rising edge
- rst_n_in  input  1  asynchronous active-low reset
- bp_en_in  input  1  enable periodic tready deassertion
- clear_in  input  1  synchronous clear of sticky error flags and frame_cnt_out
- axi_tvalid_in  input  1  stream valid
- axi_tdata_in  input  16  pixel data
- axi_tuser_in  input  1  SOF marker
- axi_tlast_in  input  1  EOL marker
- axi_tready_out  output  1  stream ready, registered
- frame_done_out  output  1  one-cycle pulse per completed frame
- frame_ok_out  output  1  result of the last completed frame; 1 = no framing errors
- checksum_out  output  32  sum of tdata over the last completed frame
- frame_cnt_out  output  16  count of completed frames, wraps at 2^16
- err_sof_out  output  1  sticky: data seen with no frame open, or tuser seen mid-frame
- err_early_eol_out  output  1  sticky: tlast before pixel HSIZE-1
- err_late_eol_out  output  1  sticky: no tlast on pixel HSIZE-1

## Operation
- Transfer (beat) = axi_tvalid_in && axi_tready_out. Nothing else advances the checking logic.
- Ready generation:
  - rdy_cnt runs free from 0 to READY_PERIOD-1 and wraps.
  - Next tready = !(bp_en_in && READY_PERIOD != 0 && rdy_cnt == READY_PERIOD-1).
  - The value is registered into axi_tready_out.
- FSM states: IDLE (waiting for SOF) and ACTIVE (frame open).
- IDLE:
  - Beat with tuser=1: pixel_cnt=1, line_cnt=0, accumulator=tdata, frame_err=0; go to ACTIVE. This beat is pixel 0.
  - Beat with tuser=0: discard the beat and set err_sof.
- ACTIVE, for each beat:
  - tuser=1: set err_sof and abort the frame (no frame_done). Restart exactly as IDLE-with-SOF, using this beat as pixel 0.
  - Otherwise add tdata (zero-extended) to the 32-bit accumulator, mod 2^32.
  - Line ends on the first of: tlast=1, or pixel_cnt == HSIZE-1.
  - tlast=1 with pixel_cnt < HSIZE-1: set err_early_eol and frame_err.
  - pixel_cnt == HSIZE-1 with tlast=0: set err_late_eol and frame_err.
  - At line end: pixel_cnt=0 and line_cnt++.
  - If the line that ended was line VSIZE-1, the frame completes:
    - pulse frame_done_out;
    - frame_ok_out = !frame_err;
    - checksum_out = final accumulator, including this beat;
    - frame_cnt_out++;
    - go to IDLE.
- Widths: pixel_cnt and line_cnt are 16 bits. HSIZE and VSIZE must be ≥ 1.
- clear_in clears the three sticky flags and frame_cnt_out. It does not affect the FSM, the counters or frame_ok_out.

## Timing
- Reset values: all outputs 0, including axi_tready_out, which rises on the first clock after reset release. FSM resets to IDLE and all counters to 0.
- frame_done_out, frame_ok_out, checksum_out and frame_cnt_out update on the clock edge that samples the last beat, so they are visible the cycle after that beat.
- Error flags set on the edge that samples the offending beat.
- clear_in and an error on the same cycle: the error wins and the flag ends set. clear_in and frame completion on the same cycle: frame_cnt_out = 1.
- Upstream holds data while tready is low. The block never drops a beat in ACTIVE.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost and no frame_done is issued.
- With bp_en_in=1 and READY_PERIOD=4, tready is low exactly 1 cycle in 4, steady state.

## Test plan
Bench parameters: HSIZE=8, VSIZE=3, READY_PERIOD=4.

- **Clean frame:** 24 beats, tdata=0..23, tuser on beat 0, tlast on beats 7/15/23, bp_en=0 -> frame_done one cycle after beat 23; frame_ok=1, checksum=276, frame_cnt=1, no error flags.
- **Early EOL:** tlast on the 6th beat of line 1, then 8-beat lines 2 and 3 -> err_early_eol=1; frame completes after 22 beats with frame_ok=0.
- **Missing tlast:** line 0 sends 8 beats with no tlast, rest clean -> err_late_eol=1; line closes at beat 7; frame_done after beat 23 with frame_ok=0.
- **Missing SOF, then clean frame:** 5 beats with tuser=0 from IDLE -> err_sof=1, no frame_done. A following clean frame gives frame_ok=1 and checksum=276.
- **Backpressure:** bp_en=1, source holds each beat until accepted -> tready low 1 cycle in 4. Clean-frame results are identical, with checksum=276.
- **Reset mid-frame:** assert rst_n_in after 10 beats -> all outputs 0. A following clean frame gives frame_cnt=1 and frame_ok=1.

Source files
------------

// File: rtl/axi_stream_checker.sv
// AXI4-Stream video sink: drives tready with optional periodic backpressure and
// checks SOF/EOL framing against HSIZE x VSIZE, reporting per-frame results.
module axi_stream_checker #(
    parameter int HSIZE        = 1920,
    parameter int VSIZE        = 3,
    parameter int READY_PERIOD = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        bp_en_in,
    input  logic        clear_in,
    input  logic        axi_tvalid_in,
    input  logic [15:0] axi_tdata_in,
    input  logic        axi_tuser_in,
    input  logic        axi_tlast_in,
    output logic        axi_tready_out,
    output logic        frame_done_out,
    output logic        frame_ok_out,
    output logic [31:0] checksum_out,
    output logic [15:0] frame_cnt_out,
    output logic        err_sof_out,
    output logic        err_early_eol_out,
    output logic        err_late_eol_out
);

    localparam int          RW     = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
    localparam logic [RW-1:0] R_LAST = RW'((READY_PERIOD > 0) ? READY_PERIOD - 1 : 0);
    localparam logic [15:0] H_LAST = 16'(HSIZE - 1);
    localparam logic [15:0] V_LAST = 16'(VSIZE - 1);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rdy_cnt;
    logic          bp_slot;
    logic [15:0]   pixel_cnt;
    logic [15:0]   line_cnt;
    logic [31:0]   acc;
    logic [31:0]   acc_next;
    logic          frame_err;

    logic          beat;
    logic          sof_start;
    logic          stray;
    logic          sof_abort;
    logic          pix_beat;
    logic          at_hlast;
    logic          line_end;
    logic          early_eol;
    logic          late_eol;
    logic          frame_end;

    // ---------------- ready generation ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rdy_cnt <= '0;
        end else if (READY_PERIOD == 0 || rdy_cnt == R_LAST) begin
            rdy_cnt <= '0;
        end else begin
            rdy_cnt <= rdy_cnt + 1'b1;
        end
    end

    assign bp_slot = bp_en_in && (READY_PERIOD != 0) && (rdy_cnt == R_LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            axi_tready_out <= 1'b0;
        end else begin
            axi_tready_out <= !bp_slot;
        end
    end

    assign beat = axi_tvalid_in && axi_tready_out;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sof_start) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (frame_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: beat decode ----------------
    // A tuser beat always (re)starts a frame; in ACTIVE it also aborts the open one.
    always_comb begin
        sof_start = beat && axi_tuser_in;
        stray     = 1'b0;
        sof_abort = 1'b0;
        pix_beat  = 1'b0;
        case (state_q)
            S_IDLE: begin
                stray = beat && !axi_tuser_in;
            end
            S_ACTIVE: begin
                sof_abort = beat && axi_tuser_in;
                pix_beat  = beat && !axi_tuser_in;
            end
            default: ;
        endcase
        at_hlast  = (pixel_cnt == H_LAST);
        line_end  = pix_beat && (axi_tlast_in || at_hlast);
        early_eol = pix_beat && axi_tlast_in && (pixel_cnt < H_LAST);
        late_eol  = pix_beat && at_hlast && !axi_tlast_in;
        frame_end = line_end && (line_cnt == V_LAST);
        acc_next  = acc + {16'd0, axi_tdata_in};
    end

    // ---------------- frame datapath ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pixel_cnt <= '0;
            line_cnt  <= '0;
            acc       <= '0;
            frame_err <= 1'b0;
        end else if (sof_start) begin
            pixel_cnt <= 16'd1;
            line_cnt  <= '0;
            acc       <= {16'd0, axi_tdata_in};
            frame_err <= 1'b0;
        end else if (pix_beat) begin
            acc       <= acc_next;
            frame_err <= frame_err | early_eol | late_eol;
            if (line_end) begin
                pixel_cnt <= '0;
                line_cnt  <= line_cnt + 16'd1;
            end else begin
                pixel_cnt <= pixel_cnt + 16'd1;
            end
        end
    end

    // ---------------- per-frame results ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_done_out <= 1'b0;
            frame_ok_out   <= 1'b0;
            checksum_out   <= '0;
        end else begin
            frame_done_out <= frame_end;
            if (frame_end) begin
                frame_ok_out <= !(frame_err | early_eol | late_eol);
                checksum_out <= acc_next;
            end
        end
    end

    // A completion on the clear cycle counts from zero, leaving the count at 1.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            frame_cnt_out <= '0;
        end else if (frame_end) begin
            frame_cnt_out <= (clear_in ? 16'd0 : frame_cnt_out) + 16'd1;
        end else if (clear_in) begin
            frame_cnt_out <= '0;
        end
    end

    // ---------------- sticky error flags (set beats clear) ----------------
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err_sof_out       <= 1'b0;
            err_early_eol_out <= 1'b0;
            err_late_eol_out  <= 1'b0;
        end else begin
            err_sof_out       <= (err_sof_out & !clear_in) | stray | sof_abort;
            err_early_eol_out <= (err_early_eol_out & !clear_in) | early_eol;
            err_late_eol_out  <= (err_late_eol_out & !clear_in) | late_eol;
        end
    end

endmodule

// File: tb/tb_axi_stream_checker.sv
// Randomized bench for axi_stream_checker with a frame-level reference model
// compared every cycle, plus hand-computed literals for the directed scenarios.
module tb_axi_stream_checker;

    localparam int H  = 8;
    localparam int V  = 3;
    localparam int RP = 4;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        bp_en_in = 1'b0;
    logic        clear_in = 1'b0;
    logic        axi_tvalid_in = 1'b0;
    logic [15:0] axi_tdata_in = '0;
    logic        axi_tuser_in = 1'b0;
    logic        axi_tlast_in = 1'b0;
    logic        axi_tready_out;
    logic        frame_done_out;
    logic        frame_ok_out;
    logic [31:0] checksum_out;
    logic [15:0] frame_cnt_out;
    logic        err_sof_out;
    logic        err_early_eol_out;
    logic        err_late_eol_out;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    bit rnd_clear = 1'b0;

    axi_stream_checker #(.HSIZE(H), .VSIZE(V), .READY_PERIOD(RP)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .bp_en_in          (bp_en_in),
        .clear_in          (clear_in),
        .axi_tvalid_in     (axi_tvalid_in),
        .axi_tdata_in      (axi_tdata_in),
        .axi_tuser_in      (axi_tuser_in),
        .axi_tlast_in      (axi_tlast_in),
        .axi_tready_out    (axi_tready_out),
        .frame_done_out    (frame_done_out),
        .frame_ok_out      (frame_ok_out),
        .checksum_out      (checksum_out),
        .frame_cnt_out     (frame_cnt_out),
        .err_sof_out       (err_sof_out),
        .err_early_eol_out (err_early_eol_out),
        .err_late_eol_out  (err_late_eol_out)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        open;
        logic [31:0] pix;
        logic [31:0] line;
        logic [31:0] sum;
        logic        ferr;
        logic [31:0] cyc;
        logic        tready;
        logic        done;
        logic        ok;
        logic [31:0] csum;
        logic [15:0] fcnt;
        logic        esof;
        logic        eearly;
        logic        elate;
    } model_t;

    model_t m;

    function automatic model_t step(model_t c, logic bp, logic clr, logic v,
                                    logic [15:0] d, logic u, logic l);
        model_t n;
        logic   eol;
        n      = c;
        n.done = 1'b0;
        // ready is low on every 4th cycle counted from reset release
        n.tready = !(bp && ((c.cyc % RP) == RP - 1));
        n.cyc    = c.cyc + 1;
        if (clr) begin
            n.esof = 1'b0; n.eearly = 1'b0; n.elate = 1'b0; n.fcnt = '0;
        end
        if (v && c.tready) begin
            if (u) begin
                if (c.open) n.esof = 1'b1;
                n.open = 1'b1; n.pix = 1; n.line = 0; n.sum = {16'd0, d}; n.ferr = 1'b0;
            end else if (!c.open) begin
                n.esof = 1'b1;
            end else begin
                n.sum = c.sum + {16'd0, d};
                eol   = l || (c.pix == H - 1);
                if (l && c.pix < H - 1) begin n.eearly = 1'b1; n.ferr = 1'b1; end
                if (!l && c.pix == H - 1) begin n.elate = 1'b1; n.ferr = 1'b1; end
                if (!eol) begin
                    n.pix = c.pix + 1;
                end else if (c.line == V - 1) begin
                    n.done = 1'b1; n.ok = !n.ferr; n.csum = n.sum;
                    n.fcnt = n.fcnt + 16'd1; n.open = 1'b0; n.pix = 0;
                end else begin
                    n.pix = 0; n.line = c.line + 1;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) m <= '0;
        else m <= step(m, bp_en_in, clear_in, axi_tvalid_in, axi_tdata_in,
                       axi_tuser_in, axi_tlast_in);
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (chk_en) begin
            chk("tready",    32'(axi_tready_out),    32'(m.tready));
            chk("frame_done", 32'(frame_done_out),   32'(m.done));
            chk("frame_ok",  32'(frame_ok_out),      32'(m.ok));
            chk("checksum",  checksum_out,           m.csum);
            chk("frame_cnt", 32'(frame_cnt_out),     32'(m.fcnt));
            chk("err_sof",   32'(err_sof_out),       32'(m.esof));
            chk("err_early", 32'(err_early_eol_out), 32'(m.eearly));
            chk("err_late",  32'(err_late_eol_out),  32'(m.elate));
        end
    end

    always @(negedge clk_in) begin
        if (rnd_clear) clear_in = ($urandom_range(0, 15) == 0);
    end

    // ---------------- stimulus ----------------
    task automatic send_beat(input logic [15:0] d, input logic u, input logic l);
        int t;
        axi_tvalid_in = 1'b1; axi_tdata_in = d; axi_tuser_in = u; axi_tlast_in = l;
        t = 0;
        while (!axi_tready_out && t < 64) begin
            @(negedge clk_in);
            t++;
        end
        if (t >= 64) begin
            checks++; failures++;
            $display("FAIL handshake_timeout got tready=0 expected 1 at %0t", $time);
        end
        @(negedge clk_in);
        axi_tvalid_in = 1'b0; axi_tuser_in = 1'b0; axi_tlast_in = 1'b0;
    endtask

    // line 0 is either first_len beats ending in tlast, or 8 beats with no tlast
    task automatic send_frame(input int first_len, input bit no_tlast);
        int idx;
        idx = 0;
        for (int i = 0; i < first_len; i++) begin
            send_beat(16'(idx), i == 0, !no_tlast && (i == first_len - 1));
            idx++;
        end
        for (int ln = 1; ln < V; ln++) begin
            for (int i = 0; i < H; i++) begin
                send_beat(16'(idx), 1'b0, i == H - 1);
                idx++;
            end
        end
    endtask

    task automatic pulse_clear();
        clear_in = 1'b1;
        @(negedge clk_in);
        clear_in = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic ok, input logic [31:0] cs,
                                input logic [15:0] fc);
        chk({tag, "_done"}, 32'(frame_done_out), 32'd1);
        chk({tag, "_ok"},   32'(frame_ok_out),   32'(ok));
        chk({tag, "_csum"}, checksum_out,        cs);
        chk({tag, "_fcnt"}, 32'(frame_cnt_out),  32'(fc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        chk_en = 1'b1;
        chk("reset_tready", 32'(axi_tready_out), 32'd0);
        chk("reset_fcnt",   32'(frame_cnt_out),  32'd0);
        chk("reset_csum",   checksum_out,        32'd0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("tready_after_release", 32'(axi_tready_out), 32'd1);

        // clean frame
        send_frame(H, 1'b0);
        check_result("clean", 1'b1, 32'd276, 16'd1);
        chk("clean_errs", {29'd0, err_sof_out, err_early_eol_out, err_late_eol_out}, 32'd0);
        @(negedge clk_in);
        chk("clean_done_pulse", 32'(frame_done_out), 32'd0);

        // early EOL: 6-beat first line
        pulse_clear();
        send_frame(6, 1'b0);
        check_result("early", 1'b0, 32'd231, 16'd1);
        chk("early_flag", 32'(err_early_eol_out), 32'd1);
        chk("early_late_flag", 32'(err_late_eol_out), 32'd0);

        // missing tlast on line 0
        pulse_clear();
        send_frame(H, 1'b1);
        check_result("late", 1'b0, 32'd276, 16'd1);
        chk("late_flag", 32'(err_late_eol_out), 32'd1);
        chk("late_early_flag", 32'(err_early_eol_out), 32'd0);

        // missing SOF then clean frame
        pulse_clear();
        for (int i = 0; i < 5; i++) send_beat(16'(100 + i), 1'b0, 1'b0);
        chk("nosof_flag", 32'(err_sof_out), 32'd1);
        chk("nosof_fcnt", 32'(frame_cnt_out), 32'd0);
        send_frame(H, 1'b0);
        check_result("nosof_clean", 1'b1, 32'd276, 16'd1);

        // backpressure
        pulse_clear();
        bp_en_in = 1'b1;
        repeat (8) @(negedge clk_in);
        lows = 0;
        repeat (40) begin
            if (!axi_tready_out) lows++;
            @(negedge clk_in);
        end
        chk("bp_low_count", 32'(lows), 32'd10);
        send_frame(H, 1'b0);
        check_result("bp", 1'b1, 32'd276, 16'd1);
        bp_en_in = 1'b0;

        // reset mid-frame
        for (int i = 0; i < 10; i++) send_beat(16'(i), i == 0, i == 7);
        rst_n_in = 1'b0;
        #1;
        chk("midrst_outs", {16'd0, frame_cnt_out} | {31'd0, axi_tready_out | frame_ok_out |
            frame_done_out | err_sof_out | err_early_eol_out | err_late_eol_out}, 32'd0);
        chk("midrst_csum", checksum_out, 32'd0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        send_frame(H, 1'b0);
        check_result("postrst", 1'b1, 32'd276, 16'd1);

        // randomized frames with occasional framing faults and clears
        rnd_clear = 1'b1;
        for (int f = 0; f < 40; f++) begin
            bp_en_in = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 7) == 0)
                for (int s = 0; s < 2; s++) send_beat(16'($urandom), 1'b0, 1'b0);
            for (int ln = 0; ln < V; ln++) begin
                int len;
                bit lst;
                len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, H + 1) : H;
                lst = ($urandom_range(0, 4) != 0);
                for (int i = 0; i < len; i++) begin
                    logic u;
                    u = (ln == 0 && i == 0) || ($urandom_range(0, 60) == 0);
                    send_beat(16'($urandom), u, lst && (i == len - 1));
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk_in);
                end
            end
        end
        rnd_clear = 1'b0;
        clear_in = 1'b0;
        repeat (4) @(negedge clk_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
